// File: rtl/lut_arbiter_if.sv
// lut_arbiter_if: requester-side bundle of the shared angle-LUT arbiter.
//   req        : level request per channel, held until the matching ack
//   req_code   : flattened codes, channel i at [i*CODE_W +: CODE_W]
//   ack        : one-hot, one-cycle completion pulse
//   resp_theta : theta for the acknowledged request
//   resp_id    : index of the acknowledged requester
// master = requesters, slave = arbiter.
interface lut_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int CODE_W  = 7,
    parameter int THETA_W = 7
);
    logic [NREQ-1:0]        req;
    logic [NREQ*CODE_W-1:0] req_code;
    logic [NREQ-1:0]        ack;
    logic [THETA_W-1:0]     resp_theta;
    logic [ID_W-1:0]        resp_id;

    modport master (
        output req, req_code,
        input  ack, resp_theta, resp_id
    );

    modport slave (
        input  req, req_code,
        output ack, resp_theta, resp_id
    );
endinterface

// File: rtl/lut_arbiter.sv
// lut_arbiter: round-robin scheduler sharing one registered-input angle LUT
// among NREQ requesters. Each conversion: grant, drive code to the LUT, wait
// out LUT latency, capture theta, return it with a one-cycle tagged ack.
// Ports:
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   rq        : requester bundle (lut_arbiter_if.slave)
//   lut_code  : registered code driven to the LUT
//   lut_theta : LUT output
//   busy      : high in every state except IDLE
module lut_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int CODE_W  = 7,
    parameter int THETA_W = 7,
    parameter int LUT_LAT = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    lut_arbiter_if.slave       rq,
    output logic [CODE_W-1:0]  lut_code,
    input  logic [THETA_W-1:0] lut_theta,
    output logic               busy
);

    localparam int CNT_W = (LUT_LAT < 2) ? 1 : $clog2(LUT_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_vld;
    logic [CNT_W-1:0]  cnt;
    int unsigned       idx;

    // Rotating priority: first set req searching upward from ptr+1 mod NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!grant_vld && rq.req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lut_code      <= '0;
            ptr           <= ID_W'(NREQ - 1);
            winner        <= '0;
            cnt           <= '0;
            rq.ack        <= '0;
            rq.resp_theta <= '0;
            rq.resp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        lut_code <= rq.req_code[grant_idx*CODE_W +: CODE_W];
                        winner   <= grant_idx;
                        ptr      <= grant_idx;
                        cnt      <= CNT_W'(LUT_LAT);
                    end
                end
                WAIT: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                CAPT: begin
                    rq.resp_theta <= lut_theta;
                    rq.resp_id    <= winner;
                    rq.ack        <= NREQ'(1) << winner;
                end
                RESP: begin
                    rq.ack <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// tb_lut_arbiter: directed vectors, hand-written corner sequences and a
// randomized run checked against a transaction-level model of the arbiter.
// The LUT is modelled as a registered-input table theta = round(acos(code/87))
// in degrees, 0 for codes above 86.
module tb_lut_arbiter;
    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int CODE_W  = 7;
    localparam int THETA_W = 7;
    localparam int LUT_LAT = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lut_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .CODE_W(CODE_W), .THETA_W(THETA_W)) rq ();

    logic [CODE_W-1:0]  lut_code;
    logic [THETA_W-1:0] lut_theta;
    logic               busy;

    lut_arbiter #(
        .NREQ(NREQ), .ID_W(ID_W), .CODE_W(CODE_W), .THETA_W(THETA_W), .LUT_LAT(LUT_LAT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .rq(rq),
        .lut_code(lut_code),
        .lut_theta(lut_theta),
        .busy(busy)
    );

    function automatic logic [THETA_W-1:0] lut_fn(input int code);
        real a;
        if (code > 86) return '0;
        a = $acos(code / 87.0) * 180.0 / 3.14159265358979;
        return THETA_W'($rtoi(a + 0.5));
    endfunction

    logic [CODE_W-1:0] lut_q = '0;
    always @(posedge clock) lut_q <= lut_code;
    assign lut_theta = lut_fn(int'(lut_q));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input int maxc, output int cyc, output logic ok);
        ok  = 1'b0;
        cyc = 0;
        for (int k = 1; k <= maxc; k++) begin
            tick();
            if (rq.ack != '0) begin
                ok  = 1'b1;
                cyc = k;
                return;
            end
        end
    endtask

    task automatic set_code(input int ch, input int code);
        rq.req_code[ch*CODE_W +: CODE_W] = CODE_W'(code);
    endtask

    typedef struct {
        int id;
        int code;
        int theta;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   prev;
        logic ok;

        vecs[0] = '{0, 0, 90};
        vecs[1] = '{0, 10, 83};
        vecs[2] = '{1, 45, 59};
        vecs[3] = '{2, 63, 44};
        vecs[4] = '{3, 86, 9};
        vecs[5] = '{3, 100, 0};
        vecs[6] = '{1, 20, 77};

        rq.req      = '0;
        rq.req_code = '0;

        // Reset state
        #12;
        check("rst_ack", rq.ack, 0);
        check("rst_theta", rq.resp_theta, 0);
        check("rst_id", rq.resp_id, 0);
        check("rst_lut_code", lut_code, 0);
        check("rst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Four simultaneous requests
        set_code(0, 10); set_code(1, 45); set_code(2, 63); set_code(3, 86);
        rq.req = 4'b1111;
        prev = 0;
        for (int j = 0; j < 4; j++) begin
            wait_ack(20, cyc, ok);
            check("sim4_ack_seen", ok, 1);
            check("sim4_ack", rq.ack, 1 << j);
            check("sim4_id", rq.resp_id, j);
            check("sim4_theta", rq.resp_theta, vecs[0].theta == 90 ?
                  (j == 0 ? 83 : j == 1 ? 59 : j == 2 ? 44 : 9) : 0);
            if (j > 0) check("sim4_spacing", cyc_cnt - prev, 5);
            prev = cyc_cnt;
            rq.req = rq.req & ~rq.ack;
        end
        tick(); tick();

        // Fairness: req0 and req2 re-raised right after each ack
        set_code(0, 30); set_code(2, 60);
        rq.req = 4'b0101;
        for (int n = 0; n < 6; n++) begin
            wait_ack(20, cyc, ok);
            check("fair_ack_seen", ok, 1);
            check("fair_id", rq.resp_id, (n % 2 == 0) ? 0 : 2);
            check("fair_ack", rq.ack, (n % 2 == 0) ? 4'b0001 : 4'b0100);
            rq.req = rq.req & ~rq.ack;
            tick();
            rq.req = rq.req | 4'b0101;
        end
        rq.req = '0;
        tick(); tick(); tick(); tick(); tick();
        check("fair_idle_ack", rq.ack, 0);

        // Table-driven single requests
        for (int i = 0; i < 7; i++) begin
            rq.req = '0;
            set_code(vecs[i].id, vecs[i].code);
            rq.req[vecs[i].id] = 1'b1;
            tick();
            check("vec_busy_grant", busy, 1);
            check("vec_lut_code", lut_code, vecs[i].code);
            wait_ack(10, cyc, ok);
            check("vec_ack_seen", ok, 1);
            check("vec_latency", cyc, 3);
            check("vec_ack", rq.ack, 1 << vecs[i].id);
            check("vec_id", rq.resp_id, vecs[i].id);
            check("vec_theta", rq.resp_theta, vecs[i].theta);
            rq.req = '0;
            tick();
            check("vec_ack_one_cycle", rq.ack, 0);
            check("vec_busy_done", busy, 0);
            check("vec_theta_hold", rq.resp_theta, vecs[i].theta);
            tick();
        end

        // Code change after grant
        set_code(1, 20);
        rq.req = 4'b0010;
        tick();
        set_code(1, 70);
        wait_ack(10, cyc, ok);
        check("chg_ack_seen", ok, 1);
        check("chg_id", rq.resp_id, 1);
        check("chg_theta", rq.resp_theta, 77);
        rq.req = '0;
        tick(); tick();

        // Reset while serving req[2] in WAIT
        set_code(2, 33);
        rq.req = 4'b0100;
        tick();
        tick();
        check("rstw_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rstw_ack", rq.ack, 0);
        check("rstw_theta", rq.resp_theta, 0);
        check("rstw_id", rq.resp_id, 0);
        check("rstw_lut_code", lut_code, 0);
        check("rstw_busy", busy, 0);
        tick(); tick(); tick();
        check("rstw_no_ack", rq.ack, 0);
        set_code(1, 45);
        rq.req = 4'b0110;
        reset_n = 1'b1;
        wait_ack(10, cyc, ok);
        check("rstw_ack_seen", ok, 1);
        check("rstw_first_id", rq.resp_id, 1);
        check("rstw_first_theta", rq.resp_theta, 59);
        rq.req = '0;
        tick(); tick();

        // Randomized run against a transaction-level model
        reset_n = 1'b0;
        tick(); tick();
        rq.req  = '0;
        reset_n = 1'b1;
        begin
            int                 ptr_m     = NREQ - 1;
            int                 next_arb  = 0;
            int                 exp_ack_c = -1;
            int                 grant_c   = -100;
            int                 exp_id    = 0;
            int                 exp_code  = 0;
            logic [THETA_W-1:0] exp_theta = '0;
            for (int c = 0; c < 2000; c++) begin
                @(posedge clock);
                if (c >= next_arb && rq.req != '0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        int j;
                        j = (ptr_m + k) % NREQ;
                        if (rq.req[j] && grant_c != c) begin
                            grant_c   = c;
                            exp_id    = j;
                        end
                    end
                    ptr_m     = exp_id;
                    exp_code  = int'(rq.req_code[exp_id*CODE_W +: CODE_W]);
                    exp_theta = lut_fn(exp_code);
                    exp_ack_c = c + LUT_LAT + 2;
                    next_arb  = c + LUT_LAT + 4;
                end
                #1;
                check("rnd_ack", rq.ack, (c == exp_ack_c) ? (1 << exp_id) : 0);
                check("rnd_busy", busy, (c >= grant_c && c < grant_c + LUT_LAT + 3) ? 1 : 0);
                if (c == grant_c) check("rnd_lut_code", lut_code, exp_code);
                if (c == exp_ack_c) begin
                    check("rnd_id", rq.resp_id, exp_id);
                    check("rnd_theta", rq.resp_theta, exp_theta);
                end
                rq.req = rq.req & ~rq.ack;
                for (int i = 0; i < NREQ; i++) begin
                    if (!rq.req[i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            set_code(i, int'($urandom_range(0, 127)));
                            rq.req[i] = 1'b1;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        set_code(i, int'($urandom_range(0, 127)));
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lut_arbiter.md
Name: lut_arbiter

Overview:
- Round-robin scheduler that shares the single registered-input angle LUT (7-bit code -> 7-bit theta) among NREQ requesting channels.
- Sequences each conversion end to end: grants one requester, drives its code to the LUT, waits out the LUT latency, captures theta, and returns it with a one-cycle acknowledge tagged by requester ID.
- Sits between the per-channel code generators and the one LUT instance, so the datapath needs only one LUT.

Parameters:
- NREQ, 4, number of requesters; 2..8.
- ID_W, 2, width of resp_id; must be at least ceil(log2(NREQ)).
- CODE_W, 7, LUT code width.
- THETA_W, 7, LUT theta width.
- LUT_LAT, 1, clock edges from a lut_code change until lut_theta is stable; 1 for the current LUT.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per channel; held until the matching ack is seen.
- req_code  in  NREQ*CODE_W  flattened codes; channel i occupies bits [i*CODE_W +: CODE_W].
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- resp_theta  out  THETA_W  theta for the acknowledged request.
- resp_id  out  ID_W  index of the acknowledged requester.
- lut_code  out  CODE_W  registered code driven to the LUT.
- lut_theta  in  THETA_W  LUT output.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (asynchronous, while reset_n is low): state=IDLE, ack=0, resp_theta=0, resp_id=0, lut_code=0, busy=0, wait counter=0, RR pointer=NREQ-1 (channel 0 has first priority).
- State machine: IDLE -> WAIT -> CAPT -> RESP -> IDLE.
- IDLE:
  - If any req bit is high at the edge, select the first set bit searching upward from pointer+1 modulo NREQ.
  - On that edge: lut_code <= req_code of the winner; winner index latched; pointer <= winner; counter <= LUT_LAT; go to WAIT.
  - With no request, stay in IDLE; lut_code holds its last value.
- WAIT:
  - While counter != 0, decrement it.
  - At the edge where counter == 0, go to CAPT.
- CAPT: at its edge, resp_theta <= lut_theta, resp_id <= winner, ack[winner] <= 1; go to RESP.
- RESP:
  - ack stays high for exactly this one cycle.
  - At its edge, ack <= 0 and go to IDLE.
  - resp_theta and resp_id hold until the next capture.
- Timing with LUT_LAT=1: grant edge E0, LUT latches the code at E1, capture at E3, ack high between E3 and E4, next arbitration at E5. Throughput is one conversion per LUT_LAT+4 cycles.
- Requester contract:
  - A requester drops req on the edge where it samples ack high.
  - The extra IDLE cycle guarantees a dropped req is never re-granted.
- Code sampling: req_code is sampled only at the grant edge. Later changes to req_code have no effect on the conversion in flight.
- req deasserted mid-transaction: the conversion still completes and ack still pulses. No abort path exists.
- Out-of-range codes (>86): passed to the LUT unchanged. The returned theta is whatever the LUT gives (0); there is no clamping or error flag.
- Simultaneous requests: exactly one grant per arbitration. Rotating priority ensures no requester waits more than NREQ-1 conversions once its req is high.
- Reset mid-operation: the in-flight conversion is discarded, no ack is issued, all outputs take reset values immediately, and the first grant after release goes to the lowest-index active requester.
- ack is always one-hot or zero. resp_id always equals the index of the set ack bit in the cycle ack is high.

Test Plan:
- Single request: req[0]=1, code 0 -> grant at E0, ack[0] high between E3 and E4, resp_theta=90, resp_id=0, busy high for E0..E4.
- Four simultaneous requests with codes 10, 45, 63, 86 -> acks in order 0, 1, 2, 3, spaced 5 cycles apart; thetas 83, 59, 44, 9.
- Fairness: req0 and req2 re-raised immediately after each ack for 6 conversions -> grant order 0, 2, 0, 2, 0, 2; req1 never acked.
- Out-of-range: req[3]=1, code 100 -> ack[3] with resp_theta=0, resp_id=3.
- Code change after grant: req[1] granted with code 20, then req_code changed to 70 during WAIT -> resp_theta=77.
- Reset in WAIT: reset_n pulsed low while serving req[2] -> no ack, all outputs 0. After release with req[1] and req[2] high, req[1] is served first.
